mano_io_intr_ctrl: RTL
======================

Name: mano_io_intr_ctrl

Overview:
- Input/output and interrupt controller for the Mano basic computer.
- Owns INPR, OUTR, FGI, FGO, IEN and the R (interrupt-cycle) flag.
- Bridges a valid/ready keyboard source and printer sink to the CPU's INP/OUT/SKI/SKO/ION/IOF instructions.
- Tells the control unit when to enter the interrupt cycle instead of the next fetch.

Parameters:
- DATA_W, 8: character width of INPR/OUTR; the AC low byte is used.
- PRT_GAP, 4: idle cycles after each printer handshake before FGO is set again; 0 is legal.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- cpu_inp  in  1  INP executing (1-cycle pulse); clears FGI
- cpu_out  in  1  OUT executing (1-cycle pulse); loads OUTR from ac_lo, clears FGO
- cpu_ion  in  1  ION pulse; sets IEN
- cpu_iof  in  1  IOF pulse; clears IEN
- instr_end  in  1  pulse on the last cycle of every instruction (outside T0-T2)
- intr_ack  in  1  pulse at RT2, end of interrupt cycle; clears R and IEN
- ac_lo  in  DATA_W  AC[DATA_W-1:0]
- inpr_out  out  DATA_W  INPR contents, muxed onto AC by the datapath
- fgi  out  1  input flag (SKI source)
- fgo  out  1  output flag (SKO source)
- ien  out  1  interrupt enable
- r_flag  out  1  interrupt cycle pending
- kbd_valid  in  1  keyboard character available
- kbd_data  in  DATA_W  keyboard character
- kbd_ready  out  1  = ~fgi (combinational from register)
- prt_valid  out  1  OUTR character presented to printer
- prt_data  out  DATA_W  = OUTR
- prt_ready  in  1  printer accepts

Behaviour:
- Reset values: INPR=0, OUTR=0, fgi=0, fgo=1, ien=0, r_flag=0, prt_valid=0, printer FSM=P_IDLE, gap counter=0.
- rst dominates every other input in the same cycle.
- Keyboard path:
  - Transfer when kbd_valid & kbd_ready; INPR<=kbd_data and fgi<=1 next cycle.
  - cpu_inp clears fgi next cycle; INPR is retained.
  - cpu_inp and kbd_valid in the same cycle with fgi=1: no transfer. kbd_ready rises the cycle after, so earliest accept is one cycle later.
  - cpu_inp with fgi=0: fgi stays 0, no other effect.
- Printer FSM states: P_IDLE, P_SEND, P_GAP.
  - P_IDLE: fgo=1. On cpu_out: OUTR<=ac_lo, fgo<=0, go to P_SEND, so prt_valid=1 on the next cycle.
  - P_SEND: prt_valid=1 and prt_data held stable until prt_ready. On the handshake cycle: if PRT_GAP=0, go to P_IDLE with fgo<=1; else load counter=PRT_GAP-1 and go to P_GAP.
  - P_GAP: counter decrements each cycle. At 0: fgo<=1, go to P_IDLE.
  - Net latency from handshake cycle M to fgo=1: cycle M+1+PRT_GAP.
  - cpu_out while fgo=0 (program error): ignored; OUTR and FSM unchanged.
- IEN:
  - cpu_ion sets it; cpu_iof clears it; iof wins if both.
  - intr_ack clears it and wins over cpu_ion in the same cycle.
- R flag:
  - Set on the cycle after instr_end when ien & (fgi | fgo), sampled at instr_end. IEN (and the masks below) are evaluated before any same-cycle ion/iof update.
  - Held until intr_ack, which clears it; set has no effect while R=1.
  - intr_ack and instr_end in the same cycle: clear wins.
  - Because fgo=1 at reset, executing ION at idle raises R at the next instruction end, per Mano semantics.

Optional Feature:
- Macro IO_INTR_MASK_EN.
- Defined:
  - Adds input ports cpu_sk_in and cpu_sk_out (1-cycle pulses) that set, and cpu_mask_clr that clears, per-source enables ie_in and ie_out.
  - Both enables reset to 1.
  - R condition becomes ien & ((fgi & ie_in) | (fgo & ie_out)).
  - ie_in and ie_out are exposed as outputs for SKI/SKO-style debug.
- Undefined: ports absent; R condition as in Behaviour.

Decomposition:
- Shared package mano_pkg:
  - DATA_W default and printer FSM state typedef (P_IDLE/P_SEND/P_GAP).
  - Constants FGO_RESET=1 and FGI_RESET=0.
- One natural sub-module: mano_prt_tx, holding the printer FSM, OUTR and the gap counter.
- Flags, IEN, R and INPR stay in the top of this block.

Test Plan:
- Reset, then kbd_valid=1 with kbd_data=0x41 for one cycle -> inpr_out=0x41, fgi=1, kbd_ready=0 next cycle. cpu_inp pulse -> fgi=0 one cycle later.
- ac_lo=0x5A, cpu_out pulse, prt_ready tied 1, PRT_GAP=4 -> prt_valid=1 for exactly 1 cycle with prt_data=0x5A; fgo=1 exactly 5 cycles after the handshake cycle.
- Second cpu_out with ac_lo=0x33 while fgo=0 -> OUTR stays 0x5A, no extra prt_valid pulse.
- cpu_ion, then instr_end with fgi=0, fgo=1 -> r_flag=1 next cycle. intr_ack -> r_flag=0 and ien=0 next cycle.
- cpu_ion and intr_ack in the same cycle -> ien=0. cpu_ion and cpu_iof in the same cycle -> ien=0.
- rst asserted mid-P_SEND with prt_ready=0 -> next cycle prt_valid=0, fgo=1, OUTR=0, r_flag=0.

Source files
------------

// File: rtl/mano_pkg.sv
// Shared definitions for the Mano basic computer I/O and interrupt controller.
package mano_pkg;

  localparam int DATA_W_DEF = 8;

  localparam logic FGO_RESET = 1'b1;
  localparam logic FGI_RESET = 1'b0;

  typedef enum logic [1:0] {
    P_IDLE = 2'd0,
    P_SEND = 2'd1,
    P_GAP  = 2'd2
  } prt_state_t;

endpackage

// File: rtl/mano_prt_tx.sv
// Printer transmit path: OUTR, the valid/ready handshake FSM and the post-handshake gap timer.
module mano_prt_tx
  import mano_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int PRT_GAP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_out,
  input  logic [DATA_W-1:0] ac_lo,
  input  logic              prt_ready,
  output logic              prt_valid,
  output logic [DATA_W-1:0] prt_data,
  output logic              fgo
);

  localparam int CNT_W = (PRT_GAP > 1) ? $clog2(PRT_GAP) : 1;
  localparam logic [CNT_W-1:0] GAP_LOAD = (PRT_GAP > 0) ? CNT_W'(PRT_GAP - 1) : '0;

  prt_state_t        state;
  prt_state_t        state_nxt;
  logic [CNT_W-1:0]  gap_cnt;
  logic [DATA_W-1:0] outr;
  logic              accept_out;
  logic              handshake;

  // OUT is only honoured while the flag is up; a second OUT is a program error and is dropped.
  assign accept_out = (state == P_IDLE) && cpu_out;
  assign handshake  = (state == P_SEND) && prt_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= P_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outr    <= '0;
      gap_cnt <= '0;
    end else begin
      if (accept_out) begin
        outr <= ac_lo;
      end
      if (handshake) begin
        gap_cnt <= GAP_LOAD;
      end else if ((state == P_GAP) && (gap_cnt != '0)) begin
        gap_cnt <= gap_cnt - CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      P_IDLE: if (cpu_out) state_nxt = P_SEND;
      P_SEND: if (prt_ready) state_nxt = (PRT_GAP == 0) ? P_IDLE : P_GAP;
      P_GAP:  if (gap_cnt == '0) state_nxt = P_IDLE;
      default: state_nxt = P_IDLE;
    endcase
  end

  // FGO is exactly "printer FSM idle", so it comes up as FGO_RESET out of reset.
  always_comb begin
    prt_valid = (state == P_SEND);
    fgo       = (state == P_IDLE);
  end

  assign prt_data = outr;

endmodule

// File: rtl/mano_io_intr_ctrl.sv
// Mano I/O and interrupt controller: INPR/FGI keyboard path, printer path, IEN and the R flag.
// Optional per-source interrupt masks are built when IO_INTR_MASK_EN is defined.
module mano_io_intr_ctrl
  import mano_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int PRT_GAP = 4
) (
  input  logic              clk,
  input  logic              rst,
`ifdef IO_INTR_MASK_EN
  input  logic              cpu_sk_in,
  input  logic              cpu_sk_out,
  input  logic              cpu_mask_clr,
  output logic              ie_in,
  output logic              ie_out,
`endif
  input  logic              cpu_inp,
  input  logic              cpu_out,
  input  logic              cpu_ion,
  input  logic              cpu_iof,
  input  logic              instr_end,
  input  logic              intr_ack,
  input  logic [DATA_W-1:0] ac_lo,
  output logic [DATA_W-1:0] inpr_out,
  output logic              fgi,
  output logic              fgo,
  output logic              ien,
  output logic              r_flag,
  input  logic              kbd_valid,
  input  logic [DATA_W-1:0] kbd_data,
  output logic              kbd_ready,
  output logic              prt_valid,
  output logic [DATA_W-1:0] prt_data,
  input  logic              prt_ready
);

  logic [DATA_W-1:0] inpr;
  logic              kbd_xfer;
  logic              intr_src;

  assign kbd_ready = ~fgi;
  assign kbd_xfer  = kbd_valid & kbd_ready;
  assign inpr_out  = inpr;

  mano_prt_tx #(
    .DATA_W  (DATA_W),
    .PRT_GAP (PRT_GAP)
  ) u_prt_tx (
    .clk       (clk),
    .rst       (rst),
    .cpu_out   (cpu_out),
    .ac_lo     (ac_lo),
    .prt_ready (prt_ready),
    .prt_valid (prt_valid),
    .prt_data  (prt_data),
    .fgo       (fgo)
  );

`ifdef IO_INTR_MASK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ie_in  <= 1'b1;
      ie_out <= 1'b1;
    end else if (cpu_mask_clr) begin
      ie_in  <= 1'b0;
      ie_out <= 1'b0;
    end else begin
      if (cpu_sk_in)  ie_in  <= 1'b1;
      if (cpu_sk_out) ie_out <= 1'b1;
    end
  end

  assign intr_src = (fgi & ie_in) | (fgo & ie_out);
`else
  assign intr_src = fgi | fgo;
`endif

  // Keyboard: a character is only taken while FGI is clear, so INP and a new key never race.
  always_ff @(posedge clk) begin
    if (rst) begin
      inpr <= '0;
      fgi  <= FGI_RESET;
    end else if (kbd_xfer) begin
      inpr <= kbd_data;
      fgi  <= 1'b1;
    end else if (cpu_inp) begin
      fgi  <= 1'b0;
    end
  end

  // R samples the pre-update IEN, so an IOF in the last cycle still lets a pending interrupt in.
  always_ff @(posedge clk) begin
    if (rst) begin
      ien    <= 1'b0;
      r_flag <= 1'b0;
    end else begin
      if (intr_ack || cpu_iof) begin
        ien <= 1'b0;
      end else if (cpu_ion) begin
        ien <= 1'b1;
      end
      if (intr_ack) begin
        r_flag <= 1'b0;
      end else if (instr_end && ien && intr_src) begin
        r_flag <= 1'b1;
      end
    end
  end

endmodule
